// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, issues one request at a time to the instruction memory and
// hands each returned word (with its PC and PC+4) to decode over valid/ready.
// Redirects from execute take effect at once; a response that was already in
// flight for the old path is flagged by kill_r and dropped when it arrives.
module fetch_ctrl #(
    parameter int unsigned             A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0]      RESET_PC = {A_WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [A_WIDTH-1:0] redirect_pc,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [A_WIDTH-1:0] instr_pc,
    output logic [A_WIDTH-1:0] instr_pc_plus4,
    output logic [31:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [A_WIDTH-1:0] PC_STEP = {{(A_WIDTH-3){1'b0}}, 3'b100};

    state_t             state_r;
    state_t             state_s;
    logic [A_WIDTH-1:0] pc_r;
    logic [A_WIDTH-1:0] pc_s;
    logic               kill_r;
    logic               kill_s;
    logic               load_s;
    logic               cnt_inc_s;
    logic               imem_req_r;
    logic               instr_valid_r;
    logic [31:0]        instr_r;
    logic [A_WIDTH-1:0] instr_pc_r;
    logic [A_WIDTH-1:0] instr_pc_plus4_r;
    logic [31:0]        fetch_cnt_r;

    // Next-state, next-PC and kill decisions; redirect overrides every other transition.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        kill_s    = kill_r;
        load_s    = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                    if (imem_gnt) begin
                        // Old address was already accepted: its response must be dropped.
                        state_s = ST_WAIT;
                        kill_s  = 1'b1;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (imem_gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                    if (imem_rvalid) begin
                        state_s = ST_REQ;
                        kill_s  = 1'b0;
                    end else begin
                        kill_s  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_r) begin
                        kill_s  = 1'b0;
                        state_s = ST_REQ;
                    end else begin
                        load_s  = 1'b1;
                        state_s = ST_HOLD;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_s    = redirect_pc;
                    state_s = ST_REQ;
                end else if (instr_ready) begin
                    pc_s      = pc_r + PC_STEP;
                    cnt_inc_s = 1'b1;
                    state_s   = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                kill_s  = 1'b0;
            end
        endcase
    end

    // Control state: FSM, PC, kill flag and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            kill_r        <= 1'b0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            kill_r        <= kill_s;
            imem_req_r    <= (state_s == ST_REQ);
            instr_valid_r <= (state_s == ST_HOLD);
        end
    end

    // Instruction output registers: loaded only on a live (not killed) response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_r          <= 32'd0;
            instr_pc_r       <= {A_WIDTH{1'b0}};
            instr_pc_plus4_r <= PC_STEP;
        end else if (load_s) begin
            instr_r          <= imem_rdata;
            instr_pc_r       <= pc_r;
            instr_pc_plus4_r <= pc_r + PC_STEP;
        end else begin
            instr_r          <= instr_r;
            instr_pc_r       <= instr_pc_r;
            instr_pc_plus4_r <= instr_pc_plus4_r;
        end
    end

    // Count of instructions accepted by decode; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_r <= 32'd0;
        end else if (cnt_inc_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end else begin
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

    assign imem_req       = imem_req_r;
    assign imem_addr      = pc_r;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign instr_pc_plus4 = instr_pc_plus4_r;
    assign fetch_cnt      = fetch_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. Inputs change 1 time unit after each
// rising edge; outputs are sampled at the same point, i.e. away from the edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [31:0] fetch_cnt;

    int checks_r = 0;
    int errors_r = 0;

    fetch_ctrl #(.A_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .fetch_cnt      (fetch_cnt)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch from REQ: grant at once, respond next cycle, decode accepts.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] exp_plus4);
        check_eq("fo_req",   {31'd0, imem_req}, 32'd1);
        check_eq("fo_addr",  imem_addr, addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check_eq("fo_req_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        check_eq("fo_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("fo_instr", instr, data);
        check_eq("fo_pc",    instr_pc, addr);
        check_eq("fo_pc4",   instr_pc_plus4, exp_plus4);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("fo_valid_drop", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        instr_ready    = 1'b0;
        tick();
        tick();
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc",    instr_pc, 32'd0);
        check_eq("rst_pc4",   instr_pc_plus4, 32'd4);
        check_eq("rst_cnt",   fetch_cnt, 32'd0);

        // Release: one IDLE cycle, then REQ.
        rst = 1'b1;
        check_eq("idle_req", {31'd0, imem_req}, 32'd0);
        tick();

        // Straight-line fetch 0, 4, 8.
        fetch_one(32'h0000_0000, 32'hA000_0000, 32'h0000_0004);
        fetch_one(32'h0000_0004, 32'hA000_0004, 32'h0000_0008);
        fetch_one(32'h0000_0008, 32'hA000_0008, 32'h0000_000C);
        check_eq("seq_cnt",  fetch_cnt, 32'd3);
        check_eq("seq_addr", imem_addr, 32'h0000_000C);

        // Backpressure in HOLD.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hB000_000C;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("bp_instr", instr, 32'hB000_000C);
            check_eq("bp_req",   {31'd0, imem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("bp_cnt",  fetch_cnt, 32'd4);
        check_eq("bp_addr", imem_addr, 32'h0000_0010);
        check_eq("bp_req1", {31'd0, imem_req}, 32'd1);

        // Redirect in WAIT before rvalid: response for 0x10 is dropped.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check_eq("rw_req0",  {31'd0, imem_req}, 32'd0);
        check_eq("rw_addr0", imem_addr, 32'h0000_0100);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0010;
        tick();
        imem_rvalid = 1'b0;
        check_eq("rw_valid", {31'd0, instr_valid}, 32'd0);
        fetch_one(32'h0000_0100, 32'hC000_0100, 32'h0000_0104);
        check_eq("rw_cnt", fetch_cnt, 32'd5);

        // Redirect in HOLD with instr_ready in the same cycle.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hC000_0104;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check_eq("rh_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rh_cnt",   fetch_cnt, 32'd5);
        check_eq("rh_addr",  imem_addr, 32'h0000_0200);
        check_eq("rh_req",   {31'd0, imem_req}, 32'd1);

        // Redirect coincident with rvalid in WAIT.
        imem_gnt = 1'b1;
        tick();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_0200;
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        check_eq("rv_valid", {31'd0, instr_valid}, 32'd0);
        fetch_one(32'h0000_0300, 32'hC000_0300, 32'h0000_0304);
        check_eq("rv_cnt", fetch_cnt, 32'd6);

        // Redirect in REQ with grant the same cycle: old response is killed.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        imem_gnt       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        check_eq("rg_req0",  {31'd0, imem_req}, 32'd0);
        check_eq("rg_addr0", imem_addr, 32'h0000_0400);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_0304;
        tick();
        imem_rvalid = 1'b0;
        check_eq("rg_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rg_req1",  {31'd0, imem_req}, 32'd1);

        // Memory stall, then redirect during the stall (no kill).
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("st_req",  {31'd0, imem_req}, 32'd1);
            check_eq("st_addr", imem_addr, 32'h0000_0400);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check_eq("st_req_r",  {31'd0, imem_req}, 32'd1);
        check_eq("st_addr_r", imem_addr, 32'h0000_0040);
        fetch_one(32'h0000_0040, 32'hC000_0040, 32'h0000_0044);
        check_eq("st_cnt", fetch_cnt, 32'd7);

        // PC wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'hE000_FFFC, 32'h0000_0000);
        check_eq("wr_addr", imem_addr, 32'h0000_0000);
        check_eq("wr_cnt",  fetch_cnt, 32'd8);

        // Asynchronous reset mid-WAIT, then a stray rvalid.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("ar_req",   {31'd0, imem_req}, 32'd0);
        check_eq("ar_addr",  imem_addr, 32'd0);
        check_eq("ar_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("ar_instr", instr, 32'd0);
        check_eq("ar_pc4",   instr_pc_plus4, 32'd4);
        check_eq("ar_cnt",   fetch_cnt, 32'd0);
        tick();
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_rvalid = 1'b0;
        check_eq("ar_stray_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("ar_stray_instr", instr, 32'd0);
        check_eq("ar_stray_req",   {31'd0, imem_req}, 32'd1);
        check_eq("ar_stray_addr",  imem_addr, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
